// File: rtl/apple2_disk_pkg.sv
// ---------------------------------------------------------------------------
// apple2_disk_pkg
// Shared constants for the Apple-II track loader and the track writeback
// engine, plus the writeback FSM state type.
//   SECTORS      : 512-byte sectors per track image
//   SECTOR_BYTES : bytes per hps_io sector
//   TRACK_BYTES  : size of the track buffer in bytes
//   TRACK_W      : width of the drive track number
// ---------------------------------------------------------------------------
package apple2_disk_pkg;

  localparam int SECTORS      = 13;
  localparam int SECTOR_BYTES = 512;
  localparam int TRACK_BYTES  = SECTORS * SECTOR_BYTES;  // 6656
  localparam int TRACK_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/disk_track_writeback.sv
// ---------------------------------------------------------------------------
// disk_track_writeback
// Watches the track buffer for writes from the disk controller and, before
// the drive leaves the track (or on an explicit flush), streams the whole
// dirty track back to the mounted image through the hps_io sector port.
// While a writeback runs, busy holds off the track loader and cpu_wait
// stalls the CPU.
//
// Ports:
//   clk_sys        system clock
//   reset          asynchronous, active-high reset
//   track          track currently selected by the drive
//   track_we       controller wrote a track RAM byte this cycle
//   flush          one-cycle request to write back the current track if dirty
//   img_mounted    pulse: new image mounted (aborts everything)
//   img_readonly   image is read-only; writes never mark the track dirty
//   img_present    image size is non-zero
//   sd_lba         sector LBA presented to hps_io
//   sd_wr          sector write request to hps_io
//   sd_ack         hps_io acknowledge, high for one sector transfer
//   sd_buff_addr   byte index within the sector, driven by hps_io
//   sd_buff_din    byte returned to hps_io (registered track RAM data)
//   tram_addr      track RAM read address {sec, sd_buff_addr}
//   tram_dout      track RAM read data (1-cycle latency)
//   busy           writeback in progress
//   cpu_wait       stall request to the CPU
//   wb_done        one-cycle pulse when a writeback completes
//   state_dbg      current FSM state (wb_state_t encoding)
//
// Handshake: sd_wr is held high from START until the rising edge of the
// ack of the last sector; every sd_ack high period is one sector transfer,
// and sector bookkeeping advances on the ack falling edge.
// ---------------------------------------------------------------------------
module disk_track_writeback #(
  parameter int SECTORS = apple2_disk_pkg::SECTORS,
  parameter int TRACK_W = apple2_disk_pkg::TRACK_W
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               track_we,
  input  logic               flush,
  input  logic               img_mounted,
  input  logic               img_readonly,
  input  logic               img_present,
  output logic [31:0]        sd_lba,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  output logic [7:0]         sd_buff_din,
  output logic [12:0]        tram_addr,
  input  logic [7:0]         tram_dout,
  output logic               busy,
  output logic               cpu_wait,
  output logic               wb_done,
  output logic [1:0]         state_dbg
);

  import apple2_disk_pkg::*;

  localparam logic [3:0] SEC_LAST = 4'(SECTORS - 1);

  wb_state_t          state;
  wb_state_t          state_nx;
  logic [TRACK_W-1:0] cur_track;
  logic [TRACK_W-1:0] wb_track;
  logic [3:0]         sec;
  logic               dirty;
  logic               redirty;
  logic               old_ack;

  logic ack_rise;
  logic ack_fall;
  logic mark;
  logic track_changed;
  logic start_wb;

  assign ack_rise      = sd_ack & ~old_ack;
  assign ack_fall      = ~sd_ack & old_ack;
  // Only writes that could ever reach the image count as modifications.
  assign mark          = track_we & ~img_readonly & img_present;
  assign track_changed = (track != cur_track);
  // A track change and a flush both write back cur_track; when they
  // coincide a single writeback covers both and the flush is consumed.
  assign start_wb      = (state == IDLE) & (track_changed | flush) &
                         dirty & img_present;

  assign tram_addr = {sec, sd_buff_addr};
  assign state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_wb) state_nx = START;
      START:   state_nx = WRITE;
      // sd_wr already dropped on the last sector's ack rise, so the
      // following fall ends the track.
      WRITE:   if (ack_fall & ~sd_wr) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (img_mounted) state_nx = IDLE;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_lba      <= 32'd0;
      sd_wr       <= 1'b0;
      sd_buff_din <= 8'd0;
      busy        <= 1'b0;
      cpu_wait    <= 1'b0;
      wb_done     <= 1'b0;
      cur_track   <= '0;
      wb_track    <= '0;
      sec         <= 4'd0;
      dirty       <= 1'b0;
      redirty     <= 1'b0;
      old_ack     <= 1'b0;
    end else begin
      old_ack     <= sd_ack;
      sd_buff_din <= tram_dout;
      wb_done     <= 1'b0;
      if (img_mounted) begin
        // A transfer already acknowledged is left to finish in hps_io;
        // its ack edges are ignored from IDLE.
        sd_wr     <= 1'b0;
        busy      <= 1'b0;
        cpu_wait  <= 1'b0;
        dirty     <= 1'b0;
        redirty   <= 1'b0;
        sec       <= 4'd0;
        cur_track <= track;
      end else begin
        case (state)
          IDLE: begin
            if (mark) dirty <= 1'b1;
            if (start_wb) begin
              wb_track <= cur_track;
              busy     <= 1'b1;
              cpu_wait <= 1'b1;
            end else if (track_changed) begin
              cur_track <= track;
            end
          end
          START: begin
            sd_lba <= 32'(wb_track) * 32'(SECTORS);
            sec    <= 4'd0;
            sd_wr  <= 1'b1;
            if (mark) redirty <= 1'b1;
          end
          WRITE: begin
            // Writes landing while the track streams out may hit sectors
            // already sent, so the track stays dirty after this pass.
            if (mark) redirty <= 1'b1;
            if (ack_rise) begin
              sd_lba <= sd_lba + 32'd1;
              if (sec == SEC_LAST) sd_wr <= 1'b0;
            end
            if (ack_fall) sec <= sec + 4'd1;
          end
          DONE: begin
            dirty     <= redirty | mark;
            redirty   <= 1'b0;
            cur_track <= track;
            busy      <= 1'b0;
            cpu_wait  <= 1'b0;
            wb_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/disk_track_writeback.md
Name: disk_track_writeback

Overview:
- Write-direction counterpart of the Apple-II track loader.
- Monitors the 6656-byte track buffer (13 × 512-byte sectors) for modifications by the disk controller.
- Before the drive moves to another track, or on an explicit flush, it writes the dirty track back to the mounted image through the hps_io sector interface (sd_wr, sd_buff_din).
- Sits in the emu top between apple2_top's track RAM and hps_io. It holds the CPU and the loader while writing.

Parameters:
- SECTORS, 13, sectors per track image (last sector index = SECTORS-1).
- TRACK_W, 6, width of the track number.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- track  in  TRACK_W  track currently selected by the drive.
- track_we  in  1  disk controller wrote a byte into the track RAM this cycle.
- flush  in  1  single-cycle request to write back the current track if it is dirty.
- img_mounted  in  1  pulse: new image mounted.
- img_readonly  in  1  image is read-only; writes are never marked dirty.
- img_present  in  1  image size is non-zero.
- sd_lba  out  32  sector LBA presented to hps_io.
- sd_wr  out  1  write request to hps_io.
- sd_ack  in  1  hps_io acknowledge; high for the duration of one sector transfer.
- sd_buff_addr  in  9  byte index within the sector, driven by hps_io.
- sd_buff_din  out  8  byte returned to hps_io.
- tram_addr  out  13  track RAM read address, = {sec[3:0], sd_buff_addr}.
- tram_dout  in  8  track RAM read data; synchronous RAM, 1-cycle latency.
- busy  out  1  writeback in progress; the loader must not start a read while high.
- cpu_wait  out  1  stall request to apple2_top.
- wb_done  out  1  single-cycle pulse when a writeback completes.

Behaviour:
- Reset values: sd_wr=0, sd_lba=0, busy=0, cpu_wait=0, wb_done=0, sd_buff_din=0, dirty=0, sec=0, state=IDLE. cur_track captures track on the first clock after reset, with no writeback.
- Data path:
  - tram_addr is combinational from the sec register and sd_buff_addr.
  - sd_buff_din is the registered tram_dout, so data is valid 2 clk_sys after sd_buff_addr changes.
- Dirty tracking:
  - dirty sets on track_we & ~img_readonly & img_present.
  - dirty clears when a writeback of that track completes.
  - A track_we during WRITE sets redirty; redirty is copied into dirty on completion.
- States:
  - IDLE:
    - If track != cur_track: if dirty & img_present, load wb_track = cur_track and go to START. Otherwise set cur_track = track and stay in IDLE.
    - Else if flush & dirty & img_present: wb_track = cur_track, go to START.
  - START (1 cycle): sd_lba = 13 × wb_track (zero-extended; max 13×63 = 819 fits), sec=0, sd_wr=1, busy=1, cpu_wait=1, go to WRITE.
  - WRITE:
    - On sd_ack rising edge (old_ack sampled each clock): sd_lba += 1, and if sec == SECTORS-1 then sd_wr=0.
    - On sd_ack falling edge: sec += 1. If sd_wr==0, go to DONE.
  - DONE (1 cycle): dirty=redirty, redirty=0, cur_track=track, busy=0, cpu_wait=0, wb_done=1, go to IDLE.
- busy rises in START and stays high until DONE. The loader, gated by busy, sees the track change only after the write completes. Exactly SECTORS ack pulses occur per writeback.
- Coincident flush and track change: the track-change path wins. It performs one writeback of cur_track; flush is dropped.
- A track change during WRITE is ignored until DONE. DONE re-samples track, so a second change is handled from IDLE on the next cycle.
- img_mounted in any state:
  - Synchronously: sd_wr=0, busy=0, cpu_wait=0, dirty=0, redirty=0, sec=0, cur_track=track, state=IDLE.
  - No wb_done pulse.
  - A transfer whose sd_ack is already high is left to finish in hps_io; it is not counted.
- reset mid-transfer: all registers return to reset values immediately. The partial track is lost, which is acceptable.
- flush while not dirty, or with img_present=0: no action.

Decomposition:
- Package apple2_disk_pkg:
  - constants SECTORS=13, SECTOR_BYTES=512, TRACK_BYTES=6656, TRACK_W=6;
  - enum wb_state_t {IDLE, START, WRITE, DONE}.
- The loader in the emu top imports the same constants.
- Single module; no sub-module is warranted. The ack edge detect is two flops inline.

Test Plan:
- Clean step: no track_we; track 5→6 → no sd_wr, busy stays 0, cur_track=6 next cycle.
- Dirty step:
  - stimulus: track_we while track=5, then track→6;
  - required: sd_wr rises with sd_lba=65;
  - 13 ack pulses, sd_lba 65→78;
  - sd_wr falls on the 13th ack rise;
  - wb_done is 1 for one clock after the 13th ack fall;
  - busy/cpu_wait are high throughout.
- Data: preload track RAM byte = addr[7:0] ^ sec. The hps model samples sd_buff_din 2 clocks after each sd_buff_addr step; sector 3 byte 0x1FF must read 0xFC.
- Flush: track_we then flush on track 34 → sd_lba starts at 442, 13 sectors. A second flush after wb_done → no action.
- Read-only: img_readonly=1, track_we bursts, then track change → no sd_wr. Redirty: track_we during sector 7 → after wb_done, flush triggers a second writeback.
- Abort: img_mounted during sector 4 → sd_wr=0 and busy=0 the next cycle, no wb_done. A later track change produces no write.
